// File: rtl/commutation_block_if.sv
// Crossbar port bundle: request channel from master, ack/response from slave.
// Modport names refer to which side drives the request channel.
interface cross_bar_if;
  logic        req;
  logic [31:0] addr;
  logic        cmd;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport master (
    output req, addr, cmd, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, addr, cmd, wdata,
    output ack, resp, rdata
  );
endinterface

// File: rtl/commutation_block.sv
// Data-path switch of the 4x4 crossbar: routes granted requests to slaves
// and steers ack/response/read data back to the owning master.
module commutation_block (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0][3:0] granted_matrix,
  cross_bar_if.slave      master_0_if,
  cross_bar_if.slave      master_1_if,
  cross_bar_if.slave      master_2_if,
  cross_bar_if.slave      master_3_if,
  cross_bar_if.master     slave_0_if,
  cross_bar_if.master     slave_1_if,
  cross_bar_if.master     slave_2_if,
  cross_bar_if.master     slave_3_if,
  output logic [3:0]      session_is_finished
);

  // rst_n is active-high despite its name.
  logic [3:0]       m_req;
  logic [3:0][31:0] m_addr;
  logic [3:0]       m_cmd;
  logic [3:0][31:0] m_wdata;
  logic [3:0]       m_ack;
  logic [3:0]       m_resp;
  logic [3:0][31:0] m_rdata;

  logic [3:0]       s_req;
  logic [3:0][31:0] s_addr;
  logic [3:0]       s_cmd;
  logic [3:0][31:0] s_wdata;
  logic [3:0]       s_ack;
  logic [3:0]       s_resp;
  logic [3:0][31:0] s_rdata;

  logic [3:0]       g_vld;
  logic [3:0][1:0]  g_idx;
  logic [3:0]       eff;

  logic [3:0]       owner_vld;
  logic [3:0][1:0]  owner_idx;

  assign m_req[0]   = master_0_if.req;
  assign m_req[1]   = master_1_if.req;
  assign m_req[2]   = master_2_if.req;
  assign m_req[3]   = master_3_if.req;
  assign m_addr[0]  = master_0_if.addr;
  assign m_addr[1]  = master_1_if.addr;
  assign m_addr[2]  = master_2_if.addr;
  assign m_addr[3]  = master_3_if.addr;
  assign m_cmd[0]   = master_0_if.cmd;
  assign m_cmd[1]   = master_1_if.cmd;
  assign m_cmd[2]   = master_2_if.cmd;
  assign m_cmd[3]   = master_3_if.cmd;
  assign m_wdata[0] = master_0_if.wdata;
  assign m_wdata[1] = master_1_if.wdata;
  assign m_wdata[2] = master_2_if.wdata;
  assign m_wdata[3] = master_3_if.wdata;

  assign master_0_if.ack   = m_ack[0];
  assign master_1_if.ack   = m_ack[1];
  assign master_2_if.ack   = m_ack[2];
  assign master_3_if.ack   = m_ack[3];
  assign master_0_if.resp  = m_resp[0];
  assign master_1_if.resp  = m_resp[1];
  assign master_2_if.resp  = m_resp[2];
  assign master_3_if.resp  = m_resp[3];
  assign master_0_if.rdata = m_rdata[0];
  assign master_1_if.rdata = m_rdata[1];
  assign master_2_if.rdata = m_rdata[2];
  assign master_3_if.rdata = m_rdata[3];

  assign s_ack[0]   = slave_0_if.ack;
  assign s_ack[1]   = slave_1_if.ack;
  assign s_ack[2]   = slave_2_if.ack;
  assign s_ack[3]   = slave_3_if.ack;
  assign s_resp[0]  = slave_0_if.resp;
  assign s_resp[1]  = slave_1_if.resp;
  assign s_resp[2]  = slave_2_if.resp;
  assign s_resp[3]  = slave_3_if.resp;
  assign s_rdata[0] = slave_0_if.rdata;
  assign s_rdata[1] = slave_1_if.rdata;
  assign s_rdata[2] = slave_2_if.rdata;
  assign s_rdata[3] = slave_3_if.rdata;

  assign slave_0_if.req   = s_req[0];
  assign slave_1_if.req   = s_req[1];
  assign slave_2_if.req   = s_req[2];
  assign slave_3_if.req   = s_req[3];
  assign slave_0_if.addr  = s_addr[0];
  assign slave_1_if.addr  = s_addr[1];
  assign slave_2_if.addr  = s_addr[2];
  assign slave_3_if.addr  = s_addr[3];
  assign slave_0_if.cmd   = s_cmd[0];
  assign slave_1_if.cmd   = s_cmd[1];
  assign slave_2_if.cmd   = s_cmd[2];
  assign slave_3_if.cmd   = s_cmd[3];
  assign slave_0_if.wdata = s_wdata[0];
  assign slave_1_if.wdata = s_wdata[1];
  assign slave_2_if.wdata = s_wdata[2];
  assign slave_3_if.wdata = s_wdata[3];

  // Grant decode: lowest set bit wins, effective only if its address matches.
  always_comb begin
    g_vld = '0;
    g_idx = '0;
    eff   = '0;
    for (int s = 0; s < 4; s++) begin
      for (int m = 3; m >= 0; m--) begin
        if (granted_matrix[s][m]) begin
          g_vld[s] = 1'b1;
          g_idx[s] = 2'(m);
        end
      end
      eff[s] = g_vld[s] && (m_addr[g_idx[s]][31:30] == 2'(s));
    end
  end

  // Request path: forward the effectively granted master, else drive zeros.
  always_comb begin
    s_req   = '0;
    s_addr  = '0;
    s_cmd   = '0;
    s_wdata = '0;
    for (int s = 0; s < 4; s++) begin
      if (eff[s]) begin
        s_req[s]   = m_req[g_idx[s]];
        s_addr[s]  = m_addr[g_idx[s]];
        s_cmd[s]   = m_cmd[g_idx[s]];
        s_wdata[s] = m_wdata[g_idx[s]];
      end
    end
  end

  // Ack path: a master only hears the slave its address selects, if granted there.
  always_comb begin
    m_ack = '0;
    for (int m = 0; m < 4; m++) begin
      if (eff[m_addr[m][31:30]] &&
          g_idx[m_addr[m][31:30]] == 2'(m)) begin
        m_ack[m] = s_ack[m_addr[m][31:30]];
      end
    end
  end

  // Owner tracking: a handshake loads the owner; a response retires it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      owner_vld <= '0;
      owner_idx <= '0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (s_req[s] && s_ack[s]) begin
          owner_vld[s] <= 1'b1;
          owner_idx[s] <= g_idx[s];
        end else if (s_resp[s] && owner_vld[s]) begin
          owner_vld[s] <= 1'b0;
        end
      end
    end
  end

  // Response path: steered by the registered owner, not the live grant.
  always_comb begin
    m_resp  = '0;
    m_rdata = '0;
    for (int s = 0; s < 4; s++) begin
      if (owner_vld[s]) begin
        m_resp[owner_idx[s]]  = m_resp[owner_idx[s]] | s_resp[s];
        m_rdata[owner_idx[s]] = m_rdata[owner_idx[s]] | s_rdata[s];
      end
    end
  end

  assign session_is_finished = s_resp & owner_vld;

endmodule

// File: tb/tb_commutation_block.sv
// Directed bench for commutation_block with hand-computed expectations.
// Inputs change #1 after a rising edge; outputs are checked before the next one.
module tb_commutation_block;

  logic            clk;
  logic            rst_n;
  logic [3:0][3:0] gm;
  logic [3:0]      fin;

  logic [3:0]       mreq;
  logic [3:0][31:0] maddr;
  logic [3:0]       mcmd;
  logic [3:0][31:0] mwdata;
  logic [3:0]       mack;
  logic [3:0]       mresp;
  logic [3:0][31:0] mrdata;

  logic [3:0]       sreq;
  logic [3:0][31:0] saddr;
  logic [3:0]       scmd;
  logic [3:0][31:0] swdata;
  logic [3:0]       sack;
  logic [3:0]       sresp;
  logic [3:0][31:0] srdata;

  int n_chk;
  int n_err;

  cross_bar_if mi0 ();
  cross_bar_if mi1 ();
  cross_bar_if mi2 ();
  cross_bar_if mi3 ();
  cross_bar_if si0 ();
  cross_bar_if si1 ();
  cross_bar_if si2 ();
  cross_bar_if si3 ();

  assign mi0.req = mreq[0];
  assign mi1.req = mreq[1];
  assign mi2.req = mreq[2];
  assign mi3.req = mreq[3];
  assign mi0.addr = maddr[0];
  assign mi1.addr = maddr[1];
  assign mi2.addr = maddr[2];
  assign mi3.addr = maddr[3];
  assign mi0.cmd = mcmd[0];
  assign mi1.cmd = mcmd[1];
  assign mi2.cmd = mcmd[2];
  assign mi3.cmd = mcmd[3];
  assign mi0.wdata = mwdata[0];
  assign mi1.wdata = mwdata[1];
  assign mi2.wdata = mwdata[2];
  assign mi3.wdata = mwdata[3];
  assign mack = {mi3.ack, mi2.ack, mi1.ack, mi0.ack};
  assign mresp = {mi3.resp, mi2.resp, mi1.resp, mi0.resp};
  assign mrdata = {mi3.rdata, mi2.rdata, mi1.rdata, mi0.rdata};

  assign si0.ack = sack[0];
  assign si1.ack = sack[1];
  assign si2.ack = sack[2];
  assign si3.ack = sack[3];
  assign si0.resp = sresp[0];
  assign si1.resp = sresp[1];
  assign si2.resp = sresp[2];
  assign si3.resp = sresp[3];
  assign si0.rdata = srdata[0];
  assign si1.rdata = srdata[1];
  assign si2.rdata = srdata[2];
  assign si3.rdata = srdata[3];
  assign sreq = {si3.req, si2.req, si1.req, si0.req};
  assign saddr = {si3.addr, si2.addr, si1.addr, si0.addr};
  assign scmd = {si3.cmd, si2.cmd, si1.cmd, si0.cmd};
  assign swdata = {si3.wdata, si2.wdata, si1.wdata, si0.wdata};

  commutation_block dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .granted_matrix      (gm),
    .master_0_if         (mi0),
    .master_1_if         (mi1),
    .master_2_if         (mi2),
    .master_3_if         (mi3),
    .slave_0_if          (si0),
    .slave_1_if          (si1),
    .slave_2_if          (si2),
    .slave_3_if          (si3),
    .session_is_finished (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mreq = '0;
    maddr = '0;
    mcmd = '0;
    mwdata = '0;
    sack = '0;
    sresp = '0;
    srdata = '0;
    gm = '0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst_n = 1'b1;

    // In reset: requests still route, responses are suppressed.
    gm[3] = 4'b1000;
    mreq[3] = 1'b1;
    maddr[3] = 32'hC000_0000;
    sresp[3] = 1'b1;
    srdata[3] = 32'h1234_5678;
    #1;
    check("rst_s3_req", 32'(sreq[3]), 32'd1);
    check("rst_fin", 32'(fin), 32'd0);
    check("rst_mresp", 32'(mresp), 32'd0);
    check("rst_m3_rdata", mrdata[3], 32'd0);
    tick();
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("idle_sreq", 32'(sreq), 32'd0);

    // No grant: request is not forwarded.
    mreq[0] = 1'b1;
    #1;
    check("nogrant_s0_req", 32'(sreq[0]), 32'd0);
    idle();

    // Master 3 write to slave 3.
    tick();
    gm[3] = 4'b1000;
    mreq[3] = 1'b1;
    maddr[3] = 32'hC000_0000;
    mcmd[3] = 1'b1;
    mwdata[3] = 32'd5;
    #1;
    check("w_s3_req", 32'(sreq[3]), 32'd1);
    check("w_s3_cmd", 32'(scmd[3]), 32'd1);
    check("w_s3_wdata", swdata[3], 32'd5);
    check("w_s3_addr", saddr[3], 32'hC000_0000);
    sack[3] = 1'b1;
    #1;
    check("w_mack", 32'(mack), 32'b1000);
    check("w_fin_pre", 32'(fin), 32'd0);
    tick();
    sack[3] = 1'b0;
    sresp[3] = 1'b1;
    mreq[3] = 1'b0;
    #1;
    check("w_m3_resp", 32'(mresp), 32'b1000);
    check("w_fin", 32'(fin), 32'b1000);
    check("w_s3_req_drop", 32'(sreq[3]), 32'd0);
    tick();
    check("w_fin_once", 32'(fin), 32'd0);
    check("w_resp_dropped", 32'(mresp), 32'd0);
    idle();

    // Masters 1 and 3 both address slave 3.
    tick();
    gm[3] = 4'b1000;
    gm[1] = 4'b0010;
    mreq[1] = 1'b1;
    maddr[1] = 32'hC000_0004;
    mwdata[1] = 32'd7;
    mreq[3] = 1'b1;
    maddr[3] = 32'hC000_0000;
    mwdata[3] = 32'd5;
    sack[3] = 1'b1;
    sack[1] = 1'b1;
    #1;
    check("two_s3_wdata", swdata[3], 32'd5);
    check("two_s1_req", 32'(sreq[1]), 32'd0);
    check("two_mack", 32'(mack), 32'b1000);
    sack = '0;
    #1;
    idle();

    // Master 0 read on slave 1; grant moves away before the response.
    gm[1] = 4'b0001;
    mreq[0] = 1'b1;
    maddr[0] = 32'h4000_0010;
    mcmd[0] = 1'b0;
    #1;
    check("r_s1_addr", saddr[1], 32'h4000_0010);
    check("r_s1_cmd", 32'(scmd[1]), 32'd0);
    sack[1] = 1'b1;
    tick();
    sack[1] = 1'b0;
    mreq[0] = 1'b0;
    gm[1] = 4'b0100;
    mreq[2] = 1'b1;
    maddr[2] = 32'h4000_0020;
    #1;
    check("r_regrant_addr", saddr[1], 32'h4000_0020);
    check("r_wait_resp", 32'(mresp), 32'd0);
    tick();
    // Response to master 0 while master 2 handshakes in the same cycle.
    sresp[1] = 1'b1;
    srdata[1] = 32'hDEAD_BEEF;
    sack[1] = 1'b1;
    #1;
    check("r_m0_resp", 32'(mresp), 32'b0001);
    check("r_m0_rdata", mrdata[0], 32'hDEAD_BEEF);
    check("r_m2_rdata", mrdata[2], 32'd0);
    check("r_fin", 32'(fin), 32'b0010);
    check("r_m2_ack", 32'(mack), 32'b0100);
    tick();
    sack[1] = 1'b0;
    mreq[2] = 1'b0;
    srdata[1] = 32'h1234_5678;
    #1;
    check("r2_m2_resp", 32'(mresp), 32'b0100);
    check("r2_m2_rdata", mrdata[2], 32'h1234_5678);
    check("r2_m0_rdata", mrdata[0], 32'd0);
    check("r2_fin", 32'(fin), 32'b0010);
    tick();
    check("r2_done", 32'(fin), 32'd0);
    idle();

    // Reset between ack and response drops the response.
    gm[2] = 4'b0010;
    mreq[1] = 1'b1;
    maddr[1] = 32'h8000_0000;
    mcmd[1] = 1'b1;
    sack[2] = 1'b1;
    tick();
    sack[2] = 1'b0;
    mreq[1] = 1'b0;
    #2;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    sresp[2] = 1'b1;
    srdata[2] = 32'hCAFE_0001;
    #1;
    check("rstmid_mresp", 32'(mresp), 32'd0);
    check("rstmid_m1_rdata", mrdata[1], 32'd0);
    check("rstmid_fin", 32'(fin), 32'd0);
    tick();
    idle();

    // Multi-bit grant: lowest set bit wins.
    gm[2] = 4'b0110;
    mreq[1] = 1'b1;
    maddr[1] = 32'h8000_0000;
    mwdata[1] = 32'h11;
    mreq[2] = 1'b1;
    maddr[2] = 32'h8000_0008;
    mwdata[2] = 32'h22;
    sack[2] = 1'b1;
    #1;
    check("multi_s2_wdata", swdata[2], 32'h11);
    check("multi_s2_addr", saddr[2], 32'h8000_0000);
    check("multi_mack", 32'(mack), 32'b0010);
    idle();
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
